// File: rtl/booth_r4_pipe_mult.sv
// Pipelined radix-4 Booth multiplier, one Booth digit per stage, valid/ready with global stall.
// Optional sideband tag ports and pipeline registers under MULT_TAG_EN.
module booth_r4_pipe_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     md_i,
  input  logic [WIDTH-1:0]     mr_i,
  input  logic                 signed_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [2*WIDTH-1:0]   result_o
`ifdef MULT_TAG_EN
  ,
  input  logic [7:0]           tag_i,
  output logic [7:0]           tag_o
`endif
);

  localparam int NDIG = WIDTH / 2 + 1;
  localparam int PW   = WIDTH + 3;

  // Stages 0..NDIG-2 live in these arrays; stage NDIG-1 is the output register.
  logic [NDIG-2:0]         vld_p;
  logic [NDIG-2:0]         sgn_p;
  logic [WIDTH-1:0]        md_p [NDIG-1];
  logic [WIDTH-1:0]        mr_p [NDIG-1];
  logic signed [PW-1:0]    ps_p [NDIG-1];
  logic [WIDTH-1:0]        lo_p [NDIG-1];
`ifdef MULT_TAG_EN
  logic [7:0]              tag_p [NDIG-1];
`endif

  logic adv;

  function automatic logic [2:0] triplet(input logic [WIDTH-1:0] mr, input logic sgn,
                                         input int k);
    logic [WIDTH+2:0] mrx;
    mrx = {{2{sgn & mr[WIDTH-1]}}, mr, 1'b0};
    return mrx[2*k+2 -: 3];
  endfunction

  function automatic logic signed [PW-1:0] booth_pp(input logic [2:0] trip,
                                                    input logic [WIDTH-1:0] md,
                                                    input logic sgn);
    logic signed [PW-1:0] m;
    m = $signed({{3{sgn & md[WIDTH-1]}}, md});
    case (trip)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m <<< 1;
      3'b100:         booth_pp = -(m <<< 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = '0;
    endcase
  endfunction

  function automatic logic signed [PW-1:0] accum(input logic signed [PW-1:0] ps,
                                                 input logic [WIDTH-1:0] md,
                                                 input logic [WIDTH-1:0] mr,
                                                 input logic sgn, input int k);
    return (ps >>> 2) + booth_pp(triplet(mr, sgn, k), md, sgn);
  endfunction

  // Retired bits enter at the top so the first-retired pair ends up at bit 0.
  function automatic logic [WIDTH-1:0] retire(input logic signed [PW-1:0] ps,
                                              input logic [WIDTH-1:0] lo);
    return {ps[1:0], lo[WIDTH-1:2]};
  endfunction

  function automatic logic [2*WIDTH-1:0] product(input logic signed [PW-1:0] ps,
                                                 input logic [WIDTH-1:0] lo,
                                                 input logic [WIDTH-1:0] md,
                                                 input logic [WIDTH-1:0] mr,
                                                 input logic sgn);
    logic signed [PW-1:0] s;
    s = accum(ps, md, mr, sgn, NDIG - 1);
    return {s[WIDTH-1:0], retire(ps, lo)};
  endfunction

  assign adv     = ready_i || !valid_o;
  assign ready_o = adv;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p    <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
`ifdef MULT_TAG_EN
      tag_o    <= '0;
`endif
    end else if (adv) begin
      vld_p[0] <= valid_i;
      for (int k = 1; k < NDIG - 1; k++) vld_p[k] <= vld_p[k-1];
      valid_o <= vld_p[NDIG-2];
      if (vld_p[NDIG-2]) begin
        result_o <= product(ps_p[NDIG-2], lo_p[NDIG-2], md_p[NDIG-2], mr_p[NDIG-2],
                            sgn_p[NDIG-2]);
`ifdef MULT_TAG_EN
        tag_o    <= tag_p[NDIG-2];
`endif
      end
    end
  end

  // Stage 0 applies digit 0 straight from the inputs; later stages shift, add and retire.
  always_ff @(posedge clk_i) begin
    if (adv) begin
      md_p[0]  <= md_i;
      mr_p[0]  <= mr_i;
      sgn_p[0] <= signed_i;
      ps_p[0]  <= booth_pp(triplet(mr_i, signed_i, 0), md_i, signed_i);
      lo_p[0]  <= '0;
`ifdef MULT_TAG_EN
      tag_p[0] <= tag_i;
`endif
      for (int k = 1; k < NDIG - 1; k++) begin
        md_p[k]  <= md_p[k-1];
        mr_p[k]  <= mr_p[k-1];
        sgn_p[k] <= sgn_p[k-1];
        ps_p[k]  <= accum(ps_p[k-1], md_p[k-1], mr_p[k-1], sgn_p[k-1], k);
        lo_p[k]  <= retire(ps_p[k-1], lo_p[k-1]);
`ifdef MULT_TAG_EN
        tag_p[k] <= tag_p[k-1];
`endif
      end
    end
  end

endmodule
